// File: rtl/bus_arbiter.sv
// bus_arbiter: grants one of NMASTERS bus masters access to the single slave port and holds the grant until the transaction ends.
// Compile with BUS_ARBITER_RR_EN defined for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module bus_arbiter #(
    parameter int NMASTERS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NMASTERS*32-1:0]   master_address,
    input  logic [NMASTERS*32-1:0]   master_wdata,
    input  logic [NMASTERS*4-1:0]    master_wsel,
    input  logic [NMASTERS-1:0]      master_valid,
    output logic [NMASTERS*32-1:0]   master_rdata,
    output logic [NMASTERS-1:0]      master_ready,
    output logic [NMASTERS-1:0]      master_error,
    output logic [31:0]              slave_address,
    output logic [31:0]              slave_wdata,
    output logic [3:0]               slave_wsel,
    output logic                     slave_valid,
    input  logic [31:0]              slave_rdata,
    input  logic                     slave_ready,
    input  logic                     slave_error
);
    // state | meaning
    // IDLE  | no grant held; picks a winner among requesting masters
    // BUSY  | grant held until slave ready/error or the granted master aborts

    localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last;
    logic [GW-1:0] winner;
    logic          done;
    logic          abort;

    assign slave_address = master_address[32*grant +: 32];
    assign slave_wdata   = master_wdata[32*grant +: 32];
    assign slave_wsel    = master_wsel[4*grant +: 4];
    assign slave_valid   = (state == BUSY) && master_valid[grant];

    // Responses only count while a request is actually presented to the slave.
    assign done  = slave_valid && (slave_ready || slave_error);
    assign abort = (state == BUSY) && !master_valid[grant];

    assign master_rdata = {NMASTERS{slave_rdata}};

    always_comb begin
        master_ready = '0;
        master_error = '0;
        if (done) begin
            master_ready[grant] = slave_ready;
            master_error[grant] = slave_error;
        end
    end

`ifdef BUS_ARBITER_RR_EN
    int            cand_i;
    logic [GW-1:0] cand;
    logic          found;

    // Search starts one past the last served master and wraps.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand_i = 0;
        cand   = '0;
        for (int k = 1; k <= NMASTERS; k++) begin
            cand_i = (int'(last) + k) % NMASTERS;
            cand   = cand_i[GW-1:0];
            if (!found && master_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NMASTERS - 1; i >= 0; i--) begin
            if (master_valid[i]) begin
                winner = GW'(i);
            end
        end
    end

    // last is still tracked in fixed-priority builds, just not consumed.
    logic unused_last;
    assign unused_last = ^last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= GW'(NMASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|master_valid) begin
                        grant <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done || abort) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized scoreboard bench for bus_arbiter against a transaction-level arbitration model.
// Honours BUS_ARBITER_RR_EN the same way as the design (round-robin when defined, fixed priority otherwise).
module tb_bus_arbiter;
    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*32-1:0]   master_address;
    logic [N*32-1:0]   master_wdata;
    logic [N*4-1:0]    master_wsel;
    logic [N-1:0]      master_valid;
    logic [N*32-1:0]   master_rdata;
    logic [N-1:0]      master_ready;
    logic [N-1:0]      master_error;
    logic [31:0]       slave_address;
    logic [31:0]       slave_wdata;
    logic [3:0]        slave_wsel;
    logic              slave_valid;
    logic [31:0]       slave_rdata;
    logic              slave_ready;
    logic              slave_error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bus_arbiter #(.NMASTERS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .master_address (master_address),
        .master_wdata   (master_wdata),
        .master_wsel    (master_wsel),
        .master_valid   (master_valid),
        .master_rdata   (master_rdata),
        .master_ready   (master_ready),
        .master_error   (master_error),
        .slave_address  (slave_address),
        .slave_wdata    (slave_wdata),
        .slave_wsel     (slave_wsel),
        .slave_valid    (slave_valid),
        .slave_rdata    (slave_rdata),
        .slave_ready    (slave_ready),
        .slave_error    (slave_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          m;
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    int    served_q[$];
    int    served_cyc[$];

    // Reference model: who owns the bus, who was served last, remaining wait states.
    int owner    = -1;
    int last_srv = N - 1;
    int wait_left = 0;

    // Stimulus knobs.
    bit          in_reset     = 1'b1;
    bit          post_rst_chk = 1'b0;
    bit          rand_fields  = 1'b1;
    bit          fix_rdata_en = 1'b0;
    logic [31:0] fix_rdata    = 32'h0;
    int          req_pct [N];
    int          fixed_wait   = 0;
    int          max_wait     = 0;
    int          resp_mode    = 1;
    int          spurious_pct = 0;
    int          abort_pct    = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int pick(logic [N-1:0] v, int lst);
`ifdef BUS_ARBITER_RR_EN
        for (int k = 1; k <= N; k++) if (v[(lst + k) % N]) return (lst + k) % N;
`else
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic issue(int i);
        if (rand_fields) begin
            master_address[i*32 +: 32] = $urandom;
            master_wdata[i*32 +: 32]   = $urandom;
            master_wsel[i*4 +: 4]      = 4'($urandom_range(15));
        end
        master_valid[i] = 1'b1;
    endtask

    task automatic set_fields(int i, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        master_address[i*32 +: 32] = a;
        master_wdata[i*32 +: 32]   = d;
        master_wsel[i*4 +: 4]      = s;
    endtask

    // One clock cycle: checks and slave response at negedge, model and master update after posedge.
    task automatic step();
        logic exp_sv;
        int   done_m;
        int   next_owner;
        int   r;
        @(negedge clk);
        exp_sv     = (owner >= 0) && master_valid[owner];
        done_m     = -1;
        next_owner = owner;
        slave_ready = 1'b0;
        slave_error = 1'b0;
        slave_rdata = fix_rdata_en ? fix_rdata : 32'($urandom);
        if (!in_reset) begin
            check("slave_valid", 64'(slave_valid), 64'(exp_sv));
            if (post_rst_chk) begin
                check("rst_master_ready", 64'(master_ready), 64'(0));
                check("rst_master_error", 64'(master_error), 64'(0));
                post_rst_chk = 1'b0;
            end
            if (exp_sv) begin
                check("slave_address", 64'(slave_address), 64'(master_address[owner*32 +: 32]));
                check("slave_wdata", 64'(slave_wdata), 64'(master_wdata[owner*32 +: 32]));
                check("slave_wsel", 64'(slave_wsel), 64'(master_wsel[owner*4 +: 4]));
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    if (resp_mode == 1) begin
                        slave_ready = 1'b1;
                    end else if (resp_mode == 2) begin
                        slave_error = 1'b1;
                    end else begin
                        r = $urandom_range(9);
                        slave_ready = (r < 7) || (r == 9);
                        slave_error = (r >= 7);
                    end
                    exp_q.push_back('{owner, slave_ready, slave_error, slave_rdata});
                    done_m = owner;
                end
            end else if ($urandom_range(99) < spurious_pct) begin
                slave_ready = 1'($urandom_range(1));
                slave_error = !slave_ready || 1'($urandom_range(1));
            end
            if (owner < 0) begin
                if (master_valid != '0) begin
                    next_owner = pick(master_valid, last_srv);
                    wait_left  = (fixed_wait >= 0) ? fixed_wait : $urandom_range(max_wait);
                end
            end else if (done_m >= 0 || !master_valid[owner]) begin
                last_srv   = owner;
                next_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        if (in_reset) begin
            owner        = -1;
            last_srv     = N - 1;
            master_valid = '0;
            exp_q.delete();
        end else begin
            owner = next_owner;
            if (done_m >= 0) master_valid[done_m] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!master_valid[i] && $urandom_range(99) < req_pct[i]) issue(i);
            if (owner >= 0 && master_valid[owner] && $urandom_range(99) < abort_pct)
                master_valid[owner] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_reset = 1'b1;
        step();
        rst          = 1'b0;
        in_reset     = 1'b0;
        post_rst_chk = 1'b1;
    endtask

    task automatic check_served(string name, int k, int exp_m);
        if (k >= 0 && k < served_q.size()) check(name, 64'(served_q[k]), 64'(exp_m));
        else check({name, "_missing"}, 64'(served_q.size()), 64'(k + 1));
    endtask

    // Monitor: whenever the DUT presents a response (or one is due) pop and compare.
    resp_t          mon_e;
    logic [N-1:0]   mon_r;
    logic [N-1:0]   mon_x;
    int             mon_idx;
    always @(negedge clk) begin
        #1;
        if (!in_reset && (((master_ready | master_error) != '0) || exp_q.size() != 0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'({master_ready, master_error}), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                mon_r = '0;
                mon_x = '0;
                mon_r[mon_e.m] = mon_e.rdy;
                mon_x[mon_e.m] = mon_e.err;
                check("resp_ready", 64'(master_ready), 64'(mon_r));
                check("resp_error", 64'(master_error), 64'(mon_x));
                check("resp_rdata", 64'(master_rdata), 64'({N{mon_e.rdata}}));
                mon_idx = -1;
                for (int i = N - 1; i >= 0; i--) if (master_ready[i] || master_error[i]) mon_idx = i;
                served_q.push_back(mon_idx);
                served_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int exp_m;
        rst            = 1'b1;
        master_address = '0;
        master_wdata   = '0;
        master_wsel    = '0;
        master_valid   = '0;
        slave_rdata    = '0;
        slave_ready    = 1'b0;
        slave_error    = 1'b0;
        for (int i = 0; i < N; i++) req_pct[i] = 0;
        step();
        reset_dut();

        // Single master 1, zero-wait slave returning 0xDEADBEEF.
        rand_fields  = 1'b0;
        fix_rdata_en = 1'b1;
        fix_rdata    = 32'hDEAD_BEEF;
        set_fields(1, 32'h8000_0010, 32'h1234_5678, 4'h0);
        issue(1);
        c0 = cyc;
        repeat (4) step();
        check_served("single_master", 0, 1);
        if (served_cyc.size() > 0) check("single_latency", 64'(served_cyc[0]), 64'(c0 + 1));
        fix_rdata_en = 1'b0;

        // Contention: both masters always requesting, zero-wait slave.
        served_q.delete();
        served_cyc.delete();
        rand_fields = 1'b1;
        reset_dut();
        req_pct[0] = 100;
        req_pct[1] = 100;
        repeat (12) step();
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_ARBITER_RR_EN
            exp_m = k % 2;
`else
            exp_m = 0;
`endif
            check_served("contention_order", k, exp_m);
        end
        for (int k = 1; k < 4; k++)
            if (k < served_cyc.size()) check("contention_spacing", 64'(served_cyc[k] - served_cyc[k-1]), 64'(2));
        req_pct[0] = 0;
        repeat (6) step();
        check_served("m1_after_m0_drops", served_q.size() - 1, 1);
        req_pct[1] = 0;
        repeat (4) step();

        // Error completion for a master 1 write, then master 0 still served.
        served_q.delete();
        served_cyc.delete();
        reset_dut();
        rand_fields = 1'b0;
        resp_mode   = 2;
        set_fields(1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF);
        issue(1);
        repeat (3) step();
        resp_mode = 1;
        set_fields(0, 32'h0000_0100, 32'h0, 4'h0);
        issue(0);
        repeat (3) step();
        check_served("error_master", 0, 1);
        check_served("after_error", 1, 0);

        // Wait states, then an abort, then a normal grant.
        served_q.delete();
        served_cyc.delete();
        fixed_wait = 3;
        set_fields(0, 32'h0000_2000, 32'h5555_AAAA, 4'h3);
        issue(0);
        repeat (6) step();
        check_served("wait_state_done", 0, 0);
        fixed_wait = 10;
        issue(0);
        repeat (3) step();
        master_valid[0] = 1'b0;
        step();
        fixed_wait = 0;
        set_fields(1, 32'h0000_3000, 32'h0, 4'h0);
        issue(1);
        repeat (4) step();
        check_served("after_abort", served_q.size() - 1, 1);
        check("abort_no_resp", 64'(served_q.size()), 64'(2));

        // Reset in the middle of a pending transaction.
        fixed_wait = 10;
        issue(0);
        repeat (3) step();
        reset_dut();
        served_q.delete();
        served_cyc.delete();
        fixed_wait  = 0;
        rand_fields = 1'b1;
        req_pct[0]  = 100;
        req_pct[1]  = 100;
        repeat (6) step();
        check_served("post_reset_first", 0, 0);

        // Randomized traffic with wait states, mixed responses, spurious responses and aborts.
        req_pct[0]   = 40;
        req_pct[1]   = 40;
        fixed_wait   = -1;
        max_wait     = 3;
        resp_mode    = 0;
        spurious_pct = 15;
        abort_pct    = 5;
        repeat (2000) step();
        req_pct[0]   = 0;
        req_pct[1]   = 0;
        abort_pct    = 0;
        spurious_pct = 0;
        repeat (20) step();
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

N-to-1 bus arbiter for the SoC's valid/ready/error bus. It sits between several bus masters (instruction port, data port, debug/DMA) and the single upstream port of the address-decoding switch. It grants one master at a time, holds the grant for the full transaction, and routes the slave's response back to the granted master only.

## Interface
- NMASTERS, 2: number of master ports (2..8).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- master_address  in  NMASTERS*32  per-master address, master i at [i*32+:32].
- master_wdata  in  NMASTERS*32  per-master write data.
- master_wsel  in  NMASTERS*4  per-master byte write select (0 = read).
- master_valid  in  NMASTERS  per-master request.
- master_rdata  out  NMASTERS*32  slave_rdata replicated to every master.
- master_ready  out  NMASTERS  transaction done; only granted bit may be 1.
- master_error  out  NMASTERS  bus error; only granted bit may be 1.
- slave_address  out  32  address of granted master.
- slave_wdata  out  32  write data of granted master.
- slave_wsel  out  4  byte select of granted master.
- slave_valid  out  1  request to slave.
- slave_rdata  in  32  read data.
- slave_ready  in  1  single-cycle completion.
- slave_error  in  1  single-cycle error completion.

## Operation
- States: IDLE, BUSY. Registers: state, grant (index, clog2(NMASTERS) bits), last (last served index).
- Reset: state=IDLE, grant=0, last=NMASTERS-1; slave_valid=0, master_ready=0, master_error=0.
- IDLE: if any master_valid bit set, pick winner, grant<=winner, state<=BUSY. Else stay.
- BUSY: slave_valid = master_valid[grant]; slave_address/wdata/wsel driven from master grant slice (also driven from grant slice in IDLE, don't-care there).
- BUSY completion: slave_ready|slave_error while slave_valid=1 -> master_ready[grant]=slave_ready, master_error[grant]=slave_error (combinational pass-through, same cycle), last<=grant, state<=IDLE.
- Error wins nothing special: if slave asserts both, both forwarded; master treats error as dominant.
- Abort: granted master drops master_valid in BUSY with no ready/error -> slave_valid=0 that cycle, state<=IDLE, last<=grant.
- Responses with slave_valid=0 (spurious ready/error) ignored; never forwarded.
- Non-granted masters never see ready/error; their requests wait, valid held.
- Masters must hold valid and request fields stable until ready/error.

## Timing
- Request sampled in IDLE at cycle N; slave_valid asserted at cycle N+1 (1-cycle arbitration latency).
- Zero-wait slave: ready at N+1 -> master_ready at N+1; arbiter IDLE at N+2; next grant at N+3. Minimum 2 cycles/transaction per master, back-to-back.
- Grant changes only on IDLE->BUSY edge; never mid-transaction.
- rst mid-BUSY: next cycle state=IDLE, slave_valid=0, all ready/error 0; in-flight transaction dropped.

## Configuration
- BUS_ARBITER_RR_EN defined: round-robin; search order last+1, last+2, ... wrapping modulo NMASTERS; first requesting index wins.
- Undefined: fixed priority; lowest requesting index wins; last register still updated but unused.

## Test plan
- Single master: NMASTERS=2, master 1 valid, addr 0x8000_0010, wsel 0x0; slave ready at first slave_valid cycle with rdata 0xDEAD_BEEF -> slave_valid one cycle after request, master_ready=2'b10, master_rdata[63:32]=0xDEAD_BEEF, master_ready[0] never 1.
- Contention, RR_EN defined: masters 0 and 1 valid continuously, zero-wait slave -> grants alternate 0,1,0,1; each completion 2 cycles apart.
- Contention, RR_EN undefined: same stimulus -> master 0 served every transaction; master 1 served only after master 0 drops valid.
- Error: slave_error=1 with slave_valid for master 1 write addr 0x0000_0004 wsel 0xF -> master_error=2'b10, master_ready=0, state returns IDLE.
- Wait states/abort: slave delays ready 3 cycles, grant and slave_address stable all 3; then master 0 drops valid in BUSY -> slave_valid=0 same cycle, next request granted normally.
- Reset mid-BUSY: rst=1 one cycle during pending transaction -> next cycle slave_valid=0, master_ready=0, master_error=0; first post-reset contention with RR grants master 0.
